// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage and its fetch queue.
package if_stage_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Small in-order queue of fetched {pc, inst} entries; head is visible without a read cycle.
module fetch_fifo
    import if_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fetch_entry_t             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_pop;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CW'(DEPTH));
    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];
    assign do_pop  = i_pop && !o_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({i_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked purely by count_q.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) mem_q[wr_ptr_q] <= i_push_data;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: issues sequential word fetches, tracks outstanding responses,
// drops stale responses after a redirect and queues the rest for decode.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_req_ready,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_inst_ready
);

    localparam int          CW       = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] QDEPTH_W = (CW + 1)'(QDEPTH);
    localparam logic [31:0] PC_INIT  = RESET_PC & ~32'h3;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] in_flight_q, in_flight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] occupancy;
    logic [CW:0]   outstanding;
    logic          req_accept;
    logic          push, pop, flush;
    logic          q_full, q_empty;
    fetch_entry_t  push_entry, head;

    // Credit uses only registered counts, so a pop never frees a slot in the same cycle.
    assign outstanding      = {1'b0, occupancy} + {1'b0, in_flight_q};
    assign o_imem_req_valid = i_rst_n && !i_redirect && (outstanding < QDEPTH_W);
    assign o_imem_addr      = pc_q;
    assign req_accept       = o_imem_req_valid && i_imem_req_ready;
    assign push_entry       = '{pc: rsp_pc_q, inst: i_imem_rsp_data};

    always_comb begin
        pc_d        = pc_q;
        rsp_pc_d    = rsp_pc_q;
        in_flight_d = in_flight_q;
        drop_d      = drop_q;
        push        = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        if (i_redirect) begin
            // Every response still owed after this cycle belongs to the old path.
            flush       = 1'b1;
            pc_d        = i_redirect_pc & ~32'h3;
            rsp_pc_d    = pc_d;
            in_flight_d = in_flight_q - CW'(i_imem_rsp_valid);
            drop_d      = in_flight_d;
        end else begin
            if (req_accept) pc_d = pc_q + 32'd4;
            pop = !q_empty && i_inst_ready;
            case ({req_accept, i_imem_rsp_valid})
                2'b10:   in_flight_d = in_flight_q + CW'(1);
                2'b01:   in_flight_d = in_flight_q - CW'(1);
                default: in_flight_d = in_flight_q;
            endcase
            if (i_imem_rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    push     = 1'b1;
                    rsp_pc_d = rsp_pc_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q        <= PC_INIT;
            rsp_pc_q    <= PC_INIT;
            in_flight_q <= '0;
            drop_q      <= '0;
        end else begin
            pc_q        <= pc_d;
            rsp_pc_q    <= rsp_pc_d;
            in_flight_q <= in_flight_d;
            drop_q      <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (push),
        .i_push_data (push_entry),
        .i_pop       (pop),
        .i_flush     (flush),
        .o_head      (head),
        .o_full      (q_full),
        .o_empty     (q_empty),
        .o_count     (occupancy)
    );

    assign o_inst_valid = !q_empty;
    assign o_inst       = q_empty ? NOP_INST : head.inst;
    assign o_pc         = q_empty ? 32'h0 : head.pc;

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(push && q_full));

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: in-order memory model with random latency/ready and a PC scoreboard.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam int          QD  = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        o_imem_req_valid;
    logic [31:0] o_imem_addr;
    logic        i_imem_req_ready;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        i_inst_ready = 1'b1;

    if_stage #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .o_imem_req_valid (o_imem_req_valid),
        .o_imem_addr      (o_imem_addr),
        .i_imem_req_ready (i_imem_req_ready),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .o_inst_valid     (o_inst_valid),
        .o_inst           (o_inst),
        .o_pc             (o_pc),
        .i_inst_ready     (i_inst_ready)
    );

    initial forever #5 i_clk = ~i_clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int lat_min = 1, lat_max = 1, ready_pct = 100;
    int consumed = 0;
    logic [31:0] last_pc = 32'h0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] model_pc = RPC;
    logic        prev_redirect = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'hA5A5_5A5A) + {a[15:0], a[31:16]};
    endfunction

    always @(posedge i_clk) cyc <= cyc + 1;

    // Memory: in order, latency lat_min..lat_max after acceptance, random ready.
    initial begin
        i_imem_req_ready = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = 32'h0;
        forever begin
            @(negedge i_clk);
            #1;
            if (!i_rst_n) begin
                pend.delete();
                i_imem_rsp_valid = 1'b0;
                i_imem_req_ready = 1'b0;
            end else begin
                if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
                    i_imem_rsp_valid = 1'b1;
                    i_imem_rsp_data  = mem_word(pend[0].addr);
                    void'(pend.pop_front());
                end else begin
                    i_imem_rsp_valid = 1'b0;
                    i_imem_rsp_data  = 32'hDEAD_BEEF;
                end
                i_imem_req_ready = ($urandom_range(99) < ready_pct);
                #2;
                if (i_rst_n && o_imem_req_valid && i_imem_req_ready)
                    pend.push_back('{o_imem_addr, cyc + 1 + int'($urandom_range(lat_max, lat_min))});
            end
        end
    end

    // Scoreboard: expected PCs pushed on accept, popped when decode consumes.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge i_clk);
            #4;
            if (!i_rst_n) begin
                exp_q.delete();
                model_pc      = RPC;
                prev_redirect = 1'b0;
            end else begin
                if (prev_redirect) begin
                    vectors++;
                    if (o_inst_valid !== 1'b0) begin
                        miscompares++;
                        $display("FAIL post_redirect_valid: got %b want 0", o_inst_valid);
                    end
                end
                if (!o_inst_valid) begin
                    vectors++;
                    if (o_inst !== NOP_INST || o_pc !== 32'h0) begin
                        miscompares++;
                        $display("FAIL idle_outputs: got inst=%h pc=%h want %h/0", o_inst, o_pc, NOP_INST);
                    end
                end
                if (i_redirect) begin
                    vectors++;
                    if (o_imem_req_valid !== 1'b0) begin
                        miscompares++;
                        $display("FAIL redirect_no_req: got %b want 0", o_imem_req_valid);
                    end
                    exp_q.delete();
                    model_pc = i_redirect_pc & ~32'h3;
                end else begin
                    if (o_inst_valid && i_inst_ready) begin
                        vectors++;
                        if (exp_q.size() == 0) begin
                            miscompares++;
                            $display("FAIL unexpected_inst: got pc=%h want none", o_pc);
                        end else begin
                            e = exp_q.pop_front();
                            if (o_pc !== e || o_inst !== mem_word(e)) begin
                                miscompares++;
                                $display("FAIL consume: got pc=%h inst=%h want pc=%h inst=%h", o_pc, o_inst, e, mem_word(e));
                            end
                        end
                        consumed++;
                        last_pc = o_pc;
                    end
                    if (o_imem_req_valid && i_imem_req_ready) begin
                        vectors++;
                        if (o_imem_addr !== model_pc) begin
                            miscompares++;
                            $display("FAIL req_addr: got %h want %h", o_imem_addr, model_pc);
                        end
                        exp_q.push_back(model_pc);
                        model_pc = model_pc + 32'd4;
                    end
                end
                prev_redirect = i_redirect;
            end
        end
    end

    task automatic wait_consume(input int n, output bit ok);
        int start = consumed;
        int k = 0;
        while (consumed < start + n && k < 500) begin
            @(negedge i_clk);
            k++;
        end
        ok = (consumed >= start + n);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        #1;
        vectors++;
        if (o_imem_req_valid !== 1'b0 || o_inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valids: got req=%b inst=%b want 0/0", o_imem_req_valid, o_inst_valid);
        end
        vectors++;
        if (o_inst !== NOP_INST || o_pc !== 32'h0 || o_imem_addr !== RPC) begin
            miscompares++;
            $display("FAIL reset_values: got inst=%h pc=%h addr=%h", o_inst, o_pc, o_imem_addr);
        end
    endtask

    task automatic test_sequential();
        lat_min = 1; lat_max = 1; ready_pct = 100; i_inst_ready = 1'b1;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        vectors++;
        if (o_imem_req_valid !== 1'b1 || o_imem_addr !== RPC) begin
            miscompares++;
            $display("FAIL first_req: got v=%b addr=%h want 1/%h", o_imem_req_valid, o_imem_addr, RPC);
        end
        @(negedge i_clk); #1;
        vectors++;
        if (o_inst_valid !== 1'b0 || o_imem_addr !== RPC + 32'd4) begin
            miscompares++;
            $display("FAIL latency_n1: got v=%b addr=%h want 0/%h", o_inst_valid, o_imem_addr, RPC + 32'd4);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk); #1;
            vectors++;
            if (o_inst_valid !== 1'b1 || o_pc !== RPC + 32'(4 * k)) begin
                miscompares++;
                $display("FAIL seq_pc%0d: got v=%b pc=%h want 1/%h", k, o_inst_valid, o_pc, RPC + 32'(4 * k));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] saved;
        bit ok;
        @(negedge i_clk);
        i_inst_ready = 1'b0;
        saved = last_pc;
        repeat (10) @(negedge i_clk);
        #1;
        vectors++;
        if (o_imem_req_valid !== 1'b0 || o_inst_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_saturate: got req=%b inst=%b want 0/1", o_imem_req_valid, o_inst_valid);
        end
        i_inst_ready = 1'b1;
        wait_consume(1, ok);
        vectors++;
        if (!ok || last_pc !== saved + 32'd4) begin
            miscompares++;
            $display("FAIL stall_resume: got pc=%h ok=%0d want %h", last_pc, ok, saved + 32'd4);
        end
        wait_consume(5, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL stall_progress: got timeout want 5 instructions");
        end
    endtask

    task automatic test_redirect();
        bit ok;
        lat_min = 3; lat_max = 3;
        repeat (8) @(negedge i_clk);
        #2;
        i_redirect_pc = 32'h0000_1002;
        i_redirect    = 1'b1;
        @(negedge i_clk);
        i_redirect = 1'b0;
        #1;
        vectors++;
        if (o_imem_addr !== 32'h0000_1000 || o_inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_addr: got addr=%h v=%b want 00001000/0", o_imem_addr, o_inst_valid);
        end
        wait_consume(1, ok);
        vectors++;
        if (!ok || last_pc !== 32'h0000_1000) begin
            miscompares++;
            $display("FAIL redirect_first_pc: got %h ok=%0d want 00001000", last_pc, ok);
        end
        wait_consume(3, ok);
    endtask

    task automatic test_redirect_collision();
        bit ok;
        lat_min = 1; lat_max = 1;
        repeat (8) @(negedge i_clk);
        #2;
        vectors++;
        if (!(i_imem_rsp_valid && o_inst_valid)) begin
            miscompares++;
            $display("FAIL collision_setup: got rsp=%b inst=%b want 1/1", i_imem_rsp_valid, o_inst_valid);
        end
        i_redirect_pc = 32'h0000_2000;
        i_redirect    = 1'b1;
        @(negedge i_clk);
        i_redirect = 1'b0;
        #1;
        vectors++;
        if (o_inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL collision_valid: got %b want 0", o_inst_valid);
        end
        wait_consume(1, ok);
        vectors++;
        if (!ok || last_pc !== 32'h0000_2000) begin
            miscompares++;
            $display("FAIL collision_first_pc: got %h ok=%0d want 00002000", last_pc, ok);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        @(negedge i_clk);
        #2;
        i_redirect_pc = 32'hFFFF_FFF6;
        i_redirect    = 1'b1;
        @(negedge i_clk);
        i_redirect = 1'b0;
        wait_consume(4, ok);
        vectors++;
        if (!ok || last_pc !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL wrap_pc: got %h ok=%0d want 00000000", last_pc, ok);
        end
    endtask

    task automatic test_random();
        int start;
        lat_min = 1; lat_max = 3; ready_pct = 60;
        start = consumed;
        repeat (300) begin
            @(negedge i_clk);
            i_inst_ready = ($urandom_range(99) < 70);
        end
        @(negedge i_clk);
        i_inst_ready = 1'b1;
        vectors++;
        if (consumed - start < 20) begin
            miscompares++;
            $display("FAIL random_progress: got %0d want >=20", consumed - start);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        repeat (7) @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        vectors++;
        if (o_imem_req_valid !== 1'b0 || o_inst_valid !== 1'b0 || o_inst !== NOP_INST ||
            o_pc !== 32'h0 || o_imem_addr !== RPC) begin
            miscompares++;
            $display("FAIL async_reset: got req=%b v=%b inst=%h pc=%h addr=%h",
                     o_imem_req_valid, o_inst_valid, o_inst, o_pc, o_imem_addr);
        end
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        vectors++;
        if (o_imem_req_valid !== 1'b1 || o_imem_addr !== RPC) begin
            miscompares++;
            $display("FAIL reset_release_req: got v=%b addr=%h want 1/%h", o_imem_req_valid, o_imem_addr, RPC);
        end
        wait_consume(1, ok);
        vectors++;
        if (!ok || last_pc !== RPC) begin
            miscompares++;
            $display("FAIL reset_release_pc: got %h ok=%0d want %h", last_pc, ok, RPC);
        end
        wait_consume(4, ok);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_collision();
        test_wrap();
        test_random();
        test_reset_mid();
        repeat (3) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want $finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 2, meaning the number of fetch-queue entries (power of two, 2..8).
REQ-003 SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port o_imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port o_imem_addr  output  32  fetch byte address, bits [1:0] always 0.
REQ-007 SHALL have port i_imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 SHALL have port i_imem_rsp_valid  input  1  instruction word returned; in order, at least 1 cycle after acceptance, never back-pressured.
REQ-009 SHALL have port i_imem_rsp_data  input  32  returned instruction word.
REQ-010 SHALL have port i_redirect  input  1  branch/jump taken; flush and restart fetch.
REQ-011 SHALL have port i_redirect_pc  input  32  restart address; bits [1:0] ignored.
REQ-012 SHALL have port o_inst_valid  output  1  decode-stage instruction valid.
REQ-013 SHALL have port o_inst  output  32  instruction to decode/immediate generation.
REQ-014 SHALL have port o_pc  output  32  address of o_inst.
REQ-015 SHALL have port i_inst_ready  input  1  decode consumes o_inst this cycle (low = stall).

Function
REQ-016 SHALL keep fetch PC, queue occupancy (0..QDEPTH), in-flight count (0..QDEPTH) and drop count (0..QDEPTH).
REQ-017 SHALL drive o_imem_req_valid = !i_redirect && (occupancy + in_flight < QDEPTH), using registered values only (no same-cycle pop credit).
REQ-018 SHALL drive o_imem_addr = fetch PC; on request accept, PC += 4 (32-bit wrap from 32'hFFFF_FFFC to 0) and in_flight += 1.
REQ-019 SHALL, on a response while drop count > 0, discard the word, decrement drop count and in_flight.
REQ-020 SHALL, on a response while drop count = 0, push {pc, word} into the queue, decrement in_flight; the PC stored is the request address.
REQ-021 SHALL present the queue head on o_inst/o_pc with o_inst_valid = (occupancy != 0); registered, no combinational path from i_imem_rsp_* to outputs.
REQ-022 SHALL pop the head when o_inst_valid && i_inst_ready; push and pop in the same cycle leave occupancy unchanged.
REQ-023 SHALL never overflow: a push into a full queue is impossible by REQ-017 and is an assertion failure.
REQ-024 SHALL, on i_redirect: empty the queue, set drop count = in_flight (plus 1 if a response arrives that same cycle is excluded, i.e. that response is discarded), set PC = {i_redirect_pc[31:2],2'b00}, issue no request that cycle.
REQ-025 SHALL give i_redirect priority over pop, push and response; o_inst_valid is 0 the cycle after a redirect.
REQ-026 SHALL drive o_inst = 32'h0000_0013 (NOP) and o_pc = 0 while o_inst_valid = 0.
REQ-027 SHALL have fetch latency: request accepted in cycle N, response in N+k, o_inst_valid in N+k+1.

Reset
REQ-028 SHALL on i_rst_n low immediately: PC = RESET_PC, occupancy/in_flight/drop = 0, o_imem_req_valid = 0, o_inst_valid = 0, o_inst = NOP, o_pc = 0.
REQ-029 SHALL issue the first request the first cycle after i_rst_n deasserts; responses to requests from before a reset mid-operation are the memory's responsibility (memory resets on the same i_rst_n).

Structure
REQ-030 SHALL place NOP constant, RESET_PC default and the fetch-entry struct {pc[31:0], inst[31:0]} in the shared pipeline package.
REQ-031 SHALL implement the queue as sub-module fetch_fifo (push, pop, flush, full, empty, count) with the counters and PC logic in if_stage.

Verification
REQ-032 Reset, 1-cycle memory, i_inst_ready=1 -> o_pc sequence 0x0,0x4,0x8 on consecutive cycles after fill, o_imem_addr advances by 4 each accept.
REQ-033 i_inst_ready=0 for 10 cycles -> occupancy saturates at QDEPTH, o_imem_req_valid=0, no word lost; release -> o_pc continues in order.
REQ-034 Redirect to 0x0000_1002 with 2 requests in flight -> both responses dropped, next o_pc = 0x0000_1000, o_imem_addr = 0x0000_1000 one cycle after redirect.
REQ-035 Redirect in same cycle as a response and a pop -> response discarded, o_inst_valid=0 next cycle, no stale PC ever appears.
REQ-036 i_imem_req_ready toggled randomly, response latency 1..3 -> o_pc strictly +4 per consumed instruction, o_inst matches memory model at o_pc.
REQ-037 Assert i_rst_n low mid-stream -> all outputs reach reset values without a clock edge; first request after release at RESET_PC.
